// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures the half-period of audioIn, locks onto a
// stable note, reports its generator period code and how many ticks it lasted.
module tone_decoder #(
    parameter int TOL     = 1,
    parameter int TICK    = 12_500_000,
    parameter int SILENCE = 2_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        audioIn,
    output logic        noteValid,
    output logic [19:0] notePeriod,
    output logic        noteDone,
    output logic [19:0] lastPeriod,
    output logic [4:0]  lastDuration,
    output logic [1:0]  o_dbg_state
);

    localparam int IW = 21;
    localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [IW-1:0] IV_MAX    = '1;
    localparam logic [IW-1:0] SIL_LAST  = IW'(SILENCE - 1);
    localparam logic [IW-1:0] TOL_V     = IW'(TOL);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
    localparam logic [4:0]    DUR_MAX   = 5'd31;

    typedef enum logic [1:0] {
        S_SILENT  = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev_smp;
    logic [IW-1:0] r_iv_cnt;
    logic [IW-1:0] r_sil_cnt;
    logic [IW-1:0] r_prev_iv;
    logic          r_prev_valid;
    logic [IW-1:0] r_lock_iv;
    logic [TW-1:0] r_tick_cnt;
    logic [4:0]    r_dur;
    logic          r_note_valid;
    logic [19:0]   r_note_period;
    logic          r_note_done;
    logic [19:0]   r_last_period;
    logic [4:0]    r_last_dur;

    logic          w_strobe;
    logic          w_timeout;
    logic [IW-1:0] w_iv;
    logic [IW-1:0] w_diff_prev;
    logic [IW-1:0] w_diff_lock;
    logic          w_match_prev;
    logic          w_match_lock;
    logic          w_tick_wrap;
    logic [4:0]    w_dur_now;
    logic          w_lock;
    logic          w_end;
    logic          w_prev_load;
    logic          w_prev_clr;

    // Both polarities of the synchronized input count as an edge.
    assign w_strobe  = r_sync2 ^ r_prev_smp;
    assign w_timeout = (r_sil_cnt == SIL_LAST) && !w_strobe;
    assign w_iv      = r_iv_cnt;

    assign w_diff_prev  = (w_iv > r_prev_iv) ? (w_iv - r_prev_iv) : (r_prev_iv - w_iv);
    assign w_diff_lock  = (w_iv > r_lock_iv) ? (w_iv - r_lock_iv) : (r_lock_iv - w_iv);
    assign w_match_prev = r_prev_valid && (w_diff_prev <= TOL_V);
    assign w_match_lock = (w_diff_lock <= TOL_V);

    // Duration including the tick that completes on this very clock.
    assign w_tick_wrap = (r_tick_cnt == TICK_LAST);
    assign w_dur_now   = (w_tick_wrap && r_dur != DUR_MAX) ? (r_dur + 5'd1) : r_dur;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_prev_smp <= 1'b0;
        end else begin
            r_sync1    <= audioIn;
            r_sync2    <= r_sync1;
            r_prev_smp <= r_sync2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_iv_cnt  <= '0;
            r_sil_cnt <= '0;
        end else if (w_strobe) begin
            r_iv_cnt  <= {{(IW-1){1'b0}}, 1'b1};
            r_sil_cnt <= '0;
        end else begin
            if (r_iv_cnt != IV_MAX) begin
                r_iv_cnt <= r_iv_cnt + 1'b1;
            end
            if (r_sil_cnt != SIL_LAST) begin
                r_sil_cnt <= r_sil_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_SILENT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_lock      = 1'b0;
        w_end       = 1'b0;
        w_prev_load = 1'b0;
        w_prev_clr  = 1'b0;
        case (r_state)
            S_SILENT: begin
                if (w_strobe) begin
                    w_state_nx = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (w_strobe) begin
                    if (w_match_prev) begin
                        w_state_nx = S_LOCKED;
                        w_lock     = 1'b1;
                    end else begin
                        w_prev_load = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_SILENT;
                    w_prev_clr = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_strobe) begin
                    if (!w_match_lock) begin
                        w_state_nx  = S_ACQUIRE;
                        w_end       = 1'b1;
                        w_prev_load = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_SILENT;
                    w_end      = 1'b1;
                    w_prev_clr = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_SILENT;
                w_prev_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_iv    <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_prev_clr) begin
            r_prev_valid <= 1'b0;
        end else if (w_prev_load) begin
            r_prev_iv    <= w_iv;
            r_prev_valid <= 1'b1;
        end
    end

    // The locked interval is frozen at lock time; jitter never moves it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_iv     <= '0;
            r_note_period <= '0;
            r_tick_cnt    <= '0;
            r_dur         <= '0;
        end else if (w_lock) begin
            r_lock_iv     <= w_iv;
            r_note_period <= 20'(w_iv - 21'd1);
            r_tick_cnt    <= '0;
            r_dur         <= '0;
        end else if (r_state == S_LOCKED) begin
            r_tick_cnt <= w_tick_wrap ? '0 : (r_tick_cnt + 1'b1);
            r_dur      <= w_dur_now;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_note_valid  <= 1'b0;
            r_note_done   <= 1'b0;
            r_last_period <= '0;
            r_last_dur    <= '0;
        end else begin
            r_note_valid <= (w_state_nx == S_LOCKED);
            r_note_done  <= w_end;
            if (w_end) begin
                r_last_period <= r_note_period;
                r_last_dur    <= w_dur_now;
            end
        end
    end

    assign noteValid    = r_note_valid;
    assign notePeriod   = r_note_period;
    assign noteDone     = r_note_done;
    assign lastPeriod   = r_last_period;
    assign lastDuration = r_last_dur;
    assign o_dbg_state  = r_state;

endmodule
